// File: rtl/keypad_scan_encoder.sv
// 4x3 matrix keypad scanner: drives rows, synchronises and debounces the column
// returns, and emits one 4-bit lock code per physical key press.
module keypad_scan_encoder #(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [1:0]    r_row;
  logic [DW-1:0] r_dwell;
  logic [3:0]    r_row_out;
  logic [1:0]    r_nkeys;
  logic [3:0]    r_fcode;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  logic          w_sample;
  logic          w_frame_end;
  logic [1:0]    w_row_low;
  logic [1:0]    w_nkeys;
  logic [3:0]    w_code;
  logic          w_none;
  logic          w_single;
  logic [1:0]    w_row_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_cnt_done;

  function automatic logic [1:0] low_count(input logic [2:0] cols);
    return {1'b0, ~cols[0]} + {1'b0, ~cols[1]} + {1'b0, ~cols[2]};
  endfunction

  // Key count only needs to distinguish none / one / many, so it saturates at 2.
  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

  function automatic logic [1:0] low_col_idx(input logic [2:0] cols);
    if (!cols[0])      return 2'd0;
    else if (!cols[1]) return 2'd1;
    else               return 2'd2;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 4'b0001;
      4'b00_01: return 4'b0010;
      4'b00_10: return 4'b0011;
      4'b01_00: return 4'b0100;
      4'b01_01: return 4'b0101;
      4'b01_10: return 4'b0110;
      4'b10_00: return 4'b0111;
      4'b10_01: return 4'b1000;
      4'b10_10: return 4'b1001;
      4'b11_00: return 4'b1101;
      4'b11_01: return 4'b0000;
      4'b11_10: return 4'b1110;
      default:  return 4'b1111;
    endcase
  endfunction

  assign w_sample    = (r_dwell == DW'(SCAN_CYCLES - 1));
  assign w_frame_end = w_sample && (r_row == 2'd3);
  assign w_row_low   = low_count(r_sync2);
  assign w_nkeys     = sat_add(r_nkeys, w_row_low);
  assign w_code      = (w_row_low == 2'd1) ? key_map(r_row, low_col_idx(r_sync2)) : r_fcode;
  assign w_none      = (w_nkeys == 2'd0);
  assign w_single    = (w_nkeys == 2'd1);
  assign w_row_next  = r_row + 2'd1;
  assign w_cnt_next  = r_cnt + CW'(1);
  assign w_cnt_done  = (w_cnt_next == CW'(DEBOUNCE_SCANS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_row       <= '0;
      r_dwell     <= '0;
      r_row_out   <= 4'b1110;
      r_nkeys     <= '0;
      r_fcode     <= '0;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_code  <= 4'b1111;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= col_in;
      r_sync2     <= r_sync1;
      r_key_code  <= 4'b1111;
      r_key_valid <= 1'b0;

      if (w_sample) begin
        r_dwell   <= '0;
        r_row     <= w_row_next;
        r_row_out <= ~(4'b0001 << w_row_next);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end

      // Per-frame accumulation restarts after the row-3 sample.
      if (w_frame_end) begin
        r_nkeys <= '0;
        r_fcode <= '0;
      end else if (w_sample) begin
        r_nkeys <= w_nkeys;
        r_fcode <= w_code;
      end

      if (w_frame_end) begin
        case (r_state)
          ST_IDLE: begin
            if (w_single) begin
              r_cand <= w_code;
              if (DEBOUNCE_SCANS == 1) begin
                r_cnt       <= '0;
                r_state     <= ST_PRESSED;
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (w_single && (w_code == r_cand)) begin
              if (w_cnt_done) begin
                r_cnt       <= '0;
                r_state     <= ST_PRESSED;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end else if (w_single) begin
              r_cand <= w_code;
              r_cnt  <= CW'(1);
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (w_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                r_cnt      <= '0;
                r_state    <= ST_IDLE;
                r_key_held <= 1'b0;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (!w_none) begin
              r_cnt   <= '0;
              r_state <= ST_PRESSED;
            end else if (w_cnt_done) begin
              r_cnt      <= '0;
              r_state    <= ST_IDLE;
              r_key_held <= 1'b0;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign row_out   = r_row_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: a behavioural keypad closes the
// row/column loop and each scenario task checks pulses, codes and timing.
module tb_keypad_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [11:0] keys = '0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         pulses = 0;
  int         bad = 0;
  int         wide = 0;
  logic       prev_v = 1'b0;
  logic [3:0] codes[$];
  int         pcyc[$];

  keypad_scan_encoder #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key (r,c) is bit r*3+c; a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (key_valid) begin
        pulses <= pulses + 1;
        codes.push_back(key_code);
        pcyc.push_back(cyc);
        if (prev_v) wide <= wide + 1;
        if (key_code == 4'hF || (key_code >= 4'hA && key_code <= 4'hC)) bad <= bad + 1;
      end else if (key_code != 4'hF) begin
        bad <= bad + 1;
      end
      prev_v <= key_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle of a frame (row 0 just driven).
  task automatic sync_frame();
    int i;
    i = 0;
    while (row_out != 4'b0111 && i < 64) begin step(1); i++; end
    while (row_out != 4'b1110 && i < 128) begin step(1); i++; end
    checks++;
    if (i >= 128) begin
      failures++;
      $display("FAIL sync_frame: row_out=%b never reached frame start", row_out);
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    step(1);
    checks++; if (row_out !== 4'b1110) begin failures++; $display("FAIL reset_row_out: got %b want 1110", row_out); end
    checks++; if (key_code !== 4'b1111) begin failures++; $display("FAIL reset_key_code: got %b want 1111", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp = ~(one << ((k / 4) % 4));
      checks++;
      if (row_out !== exp) begin
        failures++;
        $display("FAIL row_scan[%0d]: got %b want %b", k, row_out, exp);
      end
      step(1);
    end
  endtask

  task automatic test_single_press();
    int p0, c0, c1;
    sync_frame();
    p0 = pulses; c0 = cyc;
    keys = 12'b1 << 4;
    step(160);
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL press_count: got %0d want 1", pulses - p0); end
    if (pulses > p0) begin
      checks++; if (codes[p0] !== 4'b0101) begin failures++; $display("FAIL press_code: got %b want 0101", codes[p0]); end
      checks++; if (pcyc[p0] != c0 + 48) begin failures++; $display("FAIL press_latency: got %0d want %0d", pcyc[p0] - c0, 48); end
    end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held: got %b want 1", key_held); end
    keys = '0;
    c1 = cyc;
    step(47);
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL release_held_early: got %b want 1 at +%0d", key_held, cyc - c1); end
    step(1);
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL release_held_drop: got %b want 0 at +%0d", key_held, cyc - c1); end
  endtask

  task automatic test_bounce();
    int p0;
    sync_frame();
    p0 = pulses;
    keys = 12'b1;  step(16);
    keys = '0;     step(16);
    keys = 12'b1;  step(32);
    keys = '0;     step(64);
    checks++; if (pulses != p0) begin failures++; $display("FAIL bounce_count: got %0d want 0", pulses - p0); end
    checks++; if (key_code !== 4'b1111) begin failures++; $display("FAIL bounce_code: got %b want 1111", key_code); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_held: got %b want 0", key_held); end
  endtask

  task automatic test_rollover();
    int p0;
    sync_frame();
    p0 = pulses;
    keys = 12'b001; step(64);
    keys = 12'b011; step(64);
    keys = 12'b010; step(64);
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL roll_count: got %0d want 1", pulses - p0); end
    if (pulses > p0) begin
      checks++; if (codes[p0] !== 4'b0001) begin failures++; $display("FAIL roll_code: got %b want 0001", codes[p0]); end
    end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL roll_held: got %b want 1", key_held); end
    keys = '0; step(48);
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL roll_release: got %b want 0", key_held); end
    keys = 12'b100; step(48);
    checks++; if (pulses - p0 != 2) begin failures++; $display("FAIL roll_idle_count: got %0d want 2", pulses - p0); end
    if (pulses > p0 + 1) begin
      checks++; if (codes[p0+1] !== 4'b0011) begin failures++; $display("FAIL roll_idle_code: got %b want 0011", codes[p0+1]); end
    end
    keys = '0; step(64);
  endtask

  task automatic test_sequence();
    int idx[4];
    logic [3:0] exp[4];
    int p0;
    idx = '{9, 11, 10, 8};
    exp = '{4'b1101, 4'b1110, 4'b0000, 4'b1001};
    sync_frame();
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      keys = 12'b1 << idx[i]; step(80);
      keys = '0;              step(80);
    end
    checks++; if (pulses - p0 != 4) begin failures++; $display("FAIL seq_count: got %0d want 4", pulses - p0); end
    for (int i = 0; i < 4; i++) begin
      if (pulses > p0 + i) begin
        checks++;
        if (codes[p0+i] !== exp[i]) begin failures++; $display("FAIL seq_code[%0d]: got %b want %b", i, codes[p0+i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int p0, c0;
    sync_frame();
    p0 = pulses;
    keys = 12'b1 << 8;
    step(32);
    checks++; if (pulses != p0) begin failures++; $display("FAIL midrst_early: got %0d pulses want 0", pulses - p0); end
    rst = 1'b1; step(1); rst = 1'b0;
    c0 = cyc;
    checks++; if (row_out !== 4'b1110) begin failures++; $display("FAIL midrst_row: got %b want 1110", row_out); end
    checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin failures++; $display("FAIL midrst_outs: got v=%b h=%b want 0 0", key_valid, key_held); end
    step(64);
    checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL midrst_count: got %0d want 1", pulses - p0); end
    if (pulses > p0) begin
      checks++; if (codes[p0] !== 4'b1001) begin failures++; $display("FAIL midrst_code: got %b want 1001", codes[p0]); end
      checks++; if (pcyc[p0] != c0 + 48) begin failures++; $display("FAIL midrst_latency: got %0d want 48", pcyc[p0] - c0); end
    end
    keys = '0; step(64);
  endtask

  task automatic test_invariants();
    checks++; if (bad != 0) begin failures++; $display("FAIL code_invariant: got %0d bad cycles want 0", bad); end
    checks++; if (wide != 0) begin failures++; $display("FAIL pulse_width: got %0d extended pulses want 0", wide); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_rollover();
    test_sequence();
    test_reset_mid_press();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Scans a 4x3 matrix keypad, synchronises and debounces the column returns, and emits one 4-bit key code per physical press on the lock's keypad-code interface.
- Sits ahead of the electronic lock and produces the codes the lock consumes:
  - 4'b1111 = no input
  - 4'b0001..4'b1001 = digits 1..9
  - 4'b0000 = digit 0
  - 4'b1101 = cancel (*)
  - 4'b1110 = set_passcode (#)
- Each press produces exactly one non-1111 cycle, because the lock advances on every non-1111 cycle.

Parameters:
- SCAN_CYCLES, 4, clock cycles each row is driven; must be >= 3 to cover synchroniser latency.
- DEBOUNCE_SCANS, 3, consecutive identical full-frame results needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- col_in  input  3  column sense lines, active-low (pulled up), asynchronous to clk
- row_out  output  4  row drive, active-low one-hot
- key_code  output  4  keypad code; 4'b1111 except in the emit cycle
- key_valid  output  1  high for exactly the one cycle key_code is not 4'b1111
- key_held  output  1  high from the emit cycle until the release is debounced

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values:
  - row_out = 4'b1110 (row 0 driven)
  - key_code = 4'b1111, key_valid = 0, key_held = 0
  - row index, dwell counter, debounce counter, candidate and synchroniser all cleared
  - FSM = IDLE
- Synchroniser: col_in passes through a 2-flop synchroniser before any use.
- Scan:
  - Row r (0..3) is driven low for SCAN_CYCLES cycles, then the next row; row 3 wraps to row 0.
  - Synchronised columns are sampled in the last dwell cycle of each row.
  - One frame = 4*SCAN_CYCLES cycles; frame end = the row-3 sample cycle.
- Key map (row, col) -> code:
  - (0,0)=0001, (0,1)=0010, (0,2)=0011
  - (1,0)=0100, (1,1)=0101, (1,2)=0110
  - (2,0)=0111, (2,1)=1000, (2,2)=1001
  - (3,0)=1101 (*), (3,1)=0000 (0), (3,2)=1110 (#)
- Frame result, one of:
  - NONE: no low column in any row
  - SINGLE(code): exactly one key down
  - MULTI: two or more keys down
- FSM, evaluated once per frame end:
  - IDLE:
    - SINGLE(c): candidate=c, cnt=1, go to DEBOUNCE; if DEBOUNCE_SCANS==1, emit immediately and go to PRESSED.
    - NONE/MULTI: stay.
  - DEBOUNCE:
    - SINGLE(same c): cnt++; when cnt reaches DEBOUNCE_SCANS, emit and go to PRESSED.
    - SINGLE(different): restart with the new candidate, cnt=1.
    - NONE or MULTI: go to IDLE, cnt=0.
  - PRESSED:
    - NONE: cnt=1, go to RELEASE (if DEBOUNCE_SCANS==1, go straight to IDLE).
    - SINGLE/MULTI (any key, including added or rolled keys): stay; no further emit.
  - RELEASE:
    - NONE: cnt++; at DEBOUNCE_SCANS, go to IDLE and drop key_held.
    - Any key: back to PRESSED, cnt=0.
- Emit:
  - In the cycle after the accepting frame end: key_valid=1, key_code=candidate, key_held=1.
  - Next cycle: key_code=4'b1111, key_valid=0.
- Latency: press stable from frame k through k+DEBOUNCE_SCANS-1 -> emit 1 cycle after the end of frame k+DEBOUNCE_SCANS-1.
- Auto-repeat: none; a held key emits exactly once.
- key_code is never 4'b1111 while key_valid=1, and is never 4'b1010..4'b1100.
- Reset mid-operation: all state returns to reset values in the next cycle. A key held through reset is re-debounced from IDLE and emits once.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, frame = 16 cycles):
1. Assert rst 2 cycles -> row_out=1110, key_code=1111, key_valid=0, key_held=0. After release, row_out steps 1110->1101->1011->0111 every 4 cycles and wraps.
2. Model key (1,1) held 10 frames -> exactly one key_valid pulse with key_code=0101, 1 cycle after the 3rd full pressed frame end. key_held stays 1 until 3 NONE frames after release, then 0.
3. Bounce: (0,0) for 1 frame, NONE 1 frame, then (0,0) for 2 frames, then NONE -> no key_valid, key_code stays 1111 throughout.
4. Hold (0,0) to emit 0001, then add (0,1) for 4 frames, release (0,0) leaving (0,1) -> only the single 0001 pulse. Releasing all keys for 3 frames returns to IDLE.
5. Sequence *, #, 0, 9, each held 5 frames and released 5 frames -> pulses 1101, 1110, 0000, 1001 in order, each exactly 1 cycle wide.
6. Press (2,2) for 2 frames, assert rst 1 cycle, keep holding -> no emit before reset. Emit 1001 exactly once, 3 full frames after reset.
